// File: rtl/prog_load_pkg.sv
// Shared types and helpers for the UART program loader.
// Frame: 2 header bytes (word count), 4 bytes per word LSB first, 1 checksum byte.
package prog_load_pkg;

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // A word count is usable when it is non-zero and fits the ROM.
    function automatic logic count_ok(input logic [15:0] n, input int addr_w);
        return (n != 16'd0) && ({16'd0, n} <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/prog_load_timer.sv
// Inter-byte idle timer for the program loader.
// expired is high in the cycle the count reaches TIMEOUT_CYCLES while enabled.
module prog_load_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign expired = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/prog_load_ctrl.sv
// UART program download sequencer: parses the byte frame, writes the ROM
// through the upg_* port and holds the CPU in reset while the image changes.
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              cpu_hold,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    state_t      state;
    logic [15:0] n_words;
    logic [31:0] word;
    logic [1:0]  byte_idx;
    logic [7:0]  sum8;

    logic accept;
    logic start_go;
    logic expired;
    logic err_now;
    logic [31:0] next_word;

    always_comb begin
        rx_ready = (state == HDR0) || (state == HDR1)
                || (state == DATA) || (state == CSUM);
    end

    assign accept    = rx_valid && rx_ready;
    assign start_go  = start && ((state == IDLE) || (state == DONE)
                              || (state == ERR));
    assign next_word = {rx_data, word[31:8]};

    // Any failure condition this cycle: idle timeout, bad count, bad checksum.
    assign err_now = expired
        || (state == HDR1 && accept
            && !count_ok({rx_data, n_words[7:0]}, ADDR_W))
        || (state == CSUM && accept && rx_data != sum8);

    prog_load_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept || start_go),
        .en     (rx_ready && !accept),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            upg_rst_o    <= 1'b1;
            upg_wen_o    <= 1'b0;
            upg_adr_o    <= '0;
            upg_dat_o    <= '0;
            upg_done_o   <= 1'b0;
            cpu_hold     <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            n_words      <= '0;
            word         <= '0;
            byte_idx     <= '0;
            sum8         <= '0;
        end else begin
            upg_wen_o <= 1'b0;
            if (err_now) begin
                state      <= ERR;
                load_err   <= 1'b1;
                upg_done_o <= 1'b0;
                cpu_hold   <= 1'b1;
                upg_rst_o  <= 1'b1;
            end else begin
                unique case (state)
                    IDLE, DONE, ERR: begin
                        if (start_go) begin
                            state        <= HDR0;
                            upg_done_o   <= 1'b0;
                            load_err     <= 1'b0;
                            words_loaded <= '0;
                            byte_idx     <= '0;
                            sum8         <= '0;
                            cpu_hold     <= 1'b1;
                            upg_rst_o    <= 1'b0;
                        end else if (state == DONE) begin
                            state <= IDLE;
                        end
                    end
                    HDR0: begin
                        if (accept) begin
                            n_words[7:0] <= rx_data;
                            state        <= HDR1;
                        end
                    end
                    HDR1: begin
                        if (accept) begin
                            n_words[15:8] <= rx_data;
                            state         <= DATA;
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            word     <= next_word;
                            sum8     <= sum8 + rx_data;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                                state        <= WRITE;
                                upg_wen_o    <= 1'b1;
                                upg_adr_o    <= words_loaded[ADDR_W-1:0];
                                upg_dat_o    <= next_word;
                                words_loaded <= words_loaded + 16'd1;
                            end
                        end
                    end
                    WRITE: begin
                        state <= (words_loaded == n_words) ? CSUM : DATA;
                    end
                    CSUM: begin
                        if (accept) begin
                            state      <= DONE;
                            upg_done_o <= 1'b1;
                            cpu_hold   <= 1'b0;
                            upg_rst_o  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl (ADDR_W=4, TIMEOUT_CYCLES=16).
// Expected ROM writes are queued when bytes are sent and checked on each strobe.
module tb_prog_load_ctrl;

    localparam int AW = 4;
    localparam int TO = 16;

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [31:0]   dat;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          upg_rst_o;
    logic          upg_wen_o;
    logic [AW-1:0] upg_adr_o;
    logic [31:0]   upg_dat_o;
    logic          upg_done_o;
    logic          cpu_hold;
    logic          load_err;
    logic [15:0]   words_loaded;

    int  vectors;
    int  miscompares;
    wr_t exp_q[$];

    prog_load_ctrl #(
        .ADDR_W(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .upg_rst_o   (upg_rst_o),
        .upg_wen_o   (upg_wen_o),
        .upg_adr_o   (upg_adr_o),
        .upg_dat_o   (upg_dat_o),
        .upg_done_o  (upg_done_o),
        .cpu_hold    (cpu_hold),
        .load_err    (load_err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (upg_wen_o === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_wen: got adr=%h dat=%h, required no write",
                         upg_adr_o, upg_dat_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({upg_adr_o, upg_dat_o} !== {e.adr, e.dat}) begin
                    miscompares++;
                    $display("FAIL rom_write: got adr=%h dat=%h, required adr=%h dat=%h",
                             upg_adr_o, upg_dat_o, e.adr, e.dat);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_timeout: byte %h not accepted in 40 cycles", b);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a);
        wr_t e;
        e.adr = a;
        e.dat = w;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
        vectors++;
        if (upg_wen_o !== 1'b1) begin
            miscompares++;
            $display("FAIL wen_timing: got wen=%b, required 1 after 4th byte",
                     upg_wen_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({upg_rst_o, cpu_hold, upg_done_o, rx_ready, load_err, upg_wen_o}
            !== 6'b100000 || words_loaded !== 16'd0
            || upg_adr_o !== '0 || upg_dat_o !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: got rst_o=%b hold=%b done=%b rdy=%b err=%b wen=%b wl=%0d, required 1 0 0 0 0 0 0",
                     upg_rst_o, cpu_hold, upg_done_o, rx_ready, load_err,
                     upg_wen_o, words_loaded);
        end
    endtask

    task automatic load_image(input logic [7:0] csum);
        pulse_start();
        vectors++;
        if (cpu_hold !== 1'b1 || upg_rst_o !== 1'b0 || rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start: got hold=%b rst_o=%b rdy=%b, required 1 0 1",
                     cpu_hold, upg_rst_o, rx_ready);
        end
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h0000_0013, 4'd0);
        send_word(32'h0010_0093, 4'd1);
        send_byte(csum);
    endtask

    task automatic test_good_load();
        load_image(8'hB6);
        vectors++;
        if (upg_done_o !== 1'b1 || cpu_hold !== 1'b0 || upg_rst_o !== 1'b1
            || load_err !== 1'b0 || words_loaded !== 16'd2) begin
            miscompares++;
            $display("FAIL good_done: got done=%b hold=%b rst_o=%b err=%b wl=%0d, required 1 0 1 0 2",
                     upg_done_o, cpu_hold, upg_rst_o, load_err, words_loaded);
        end
        @(negedge clk);
        vectors++;
        if (upg_done_o !== 1'b1 || rx_ready !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL good_idle: got done=%b rdy=%b pending=%0d, required 1 0 0",
                     upg_done_o, rx_ready, exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        load_image(8'hB5);
        vectors++;
        if (load_err !== 1'b1 || upg_done_o !== 1'b0 || cpu_hold !== 1'b1
            || upg_rst_o !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_csum: got err=%b done=%b hold=%b rst_o=%b, required 1 0 1 1",
                     load_err, upg_done_o, cpu_hold, upg_rst_o);
        end
        repeat (3) @(negedge clk);
        pulse_start();
        vectors++;
        if (load_err !== 1'b0 || cpu_hold !== 1'b1 || words_loaded !== 16'd0) begin
            miscompares++;
            $display("FAIL restart_clear: got err=%b hold=%b wl=%0d, required 0 1 0",
                     load_err, cpu_hold, words_loaded);
        end
    endtask

    task automatic test_bad_header();
        send_byte(8'h00);
        send_byte(8'h00);
        vectors++;
        if (load_err !== 1'b1 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hdr_zero: got err=%b rdy=%b, required 1 0",
                     load_err, rx_ready);
        end
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h00);
        vectors++;
        if (load_err !== 1'b1) begin
            miscompares++;
            $display("FAIL hdr_too_big: got err=%b, required 1", load_err);
        end
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h00);
        vectors++;
        if (load_err !== 1'b0 || rx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hdr_max: got err=%b rdy=%b, required 0 1",
                     load_err, rx_ready);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        send_byte(8'h00);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (k >= TO - 2) begin
                vectors++;
                if (load_err !== (k == TO)) begin
                    miscompares++;
                    $display("FAIL timeout_k%0d: got err=%b, required %b",
                             k, load_err, (k == TO));
                end
            end
        end
        vectors++;
        if (cpu_hold !== 1'b1 || upg_rst_o !== 1'b1 || rx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_state: got hold=%b rst_o=%b rdy=%b, required 1 1 0",
                     cpu_hold, upg_rst_o, rx_ready);
        end
    endtask

    task automatic test_reset_mid_data();
        do_reset();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({upg_rst_o, cpu_hold, upg_done_o, rx_ready, load_err} !== 5'b10000
            || words_loaded !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got rst_o=%b hold=%b done=%b rdy=%b err=%b wl=%0d, required 1 0 0 0 0 0",
                     upg_rst_o, cpu_hold, upg_done_o, rx_ready, load_err,
                     words_loaded);
        end
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        repeat (6) @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if (rx_ready !== 1'b0 || cpu_hold !== 1'b0 || upg_rst_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_bytes: got rdy=%b hold=%b rst_o=%b, required 0 0 1",
                     rx_ready, cpu_hold, upg_rst_o);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        start       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        @(negedge clk);
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_bad_header();
        test_timeout();
        test_reset_mid_data();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: got %0d pending, required 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
